// File: rtl/rob.sv
// ---------------------------------------------------------------------------
// rob: reorder buffer
//
// Entries are allocated in order at dispatch, marked done out of order by up
// to CDB_PORTS completion ports, and retired in order, up to RETIRE_WIDTH
// entries per cycle. Retirement commits rd->prd and returns the old physical
// tag to the free pool.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   flush          synchronous squash of every entry
//   alloc_*        dispatch request and entry payload; alloc_idx = tail (rob_num)
//   cmpl_valid/idx per-port completion strobe and index (port p at [p*IDX_W +: IDX_W])
//   ret_*          per-lane retirement outputs (zero when the lane is idle)
//   free_push/reg  per-lane old tag return (retiring & reg_wr)
//   count          number of occupied entries
//
// Handshake: an allocation happens on a rising edge where alloc_valid and
// alloc_ready are both high. alloc_ready comes only from the registered count,
// so it never depends on alloc_valid or on a retirement in the same cycle.
// Completion and retirement have no back-pressure.
// ---------------------------------------------------------------------------
module rob #(
    parameter int DEPTH        = 64,
    parameter int IDX_W        = 6,
    parameter int PREG_WIDTH   = 6,
    parameter int AREG_WIDTH   = 5,
    parameter int CDB_PORTS    = 3,
    parameter int RETIRE_WIDTH = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               alloc_valid,
    output logic                               alloc_ready,
    input  logic                               alloc_reg_wr,
    input  logic [AREG_WIDTH-1:0]              alloc_rd,
    input  logic [PREG_WIDTH-1:0]              alloc_prd,
    input  logic [PREG_WIDTH-1:0]              alloc_old_prd,
    input  logic [11:0]                        alloc_pc,
    output logic [IDX_W-1:0]                   alloc_idx,
    input  logic [CDB_PORTS-1:0]               cmpl_valid,
    input  logic [CDB_PORTS*IDX_W-1:0]         cmpl_idx,
    output logic [RETIRE_WIDTH-1:0]            ret_valid,
    output logic [RETIRE_WIDTH*AREG_WIDTH-1:0] ret_rd,
    output logic [RETIRE_WIDTH*PREG_WIDTH-1:0] ret_prd,
    output logic [RETIRE_WIDTH*12-1:0]         ret_pc,
    output logic [RETIRE_WIDTH-1:0]            free_push,
    output logic [RETIRE_WIDTH*PREG_WIDTH-1:0] free_reg,
    output logic [IDX_W:0]                     count
);

    localparam int NRET_W = $clog2(RETIRE_WIDTH + 1);

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      done_q, done_d;
    logic [DEPTH-1:0]      reg_wr_q, reg_wr_d;
    logic [AREG_WIDTH-1:0] rd_q      [DEPTH];
    logic [AREG_WIDTH-1:0] rd_d      [DEPTH];
    logic [PREG_WIDTH-1:0] prd_q     [DEPTH];
    logic [PREG_WIDTH-1:0] prd_d     [DEPTH];
    logic [PREG_WIDTH-1:0] old_prd_q [DEPTH];
    logic [PREG_WIDTH-1:0] old_prd_d [DEPTH];
    logic [11:0]           pc_q      [DEPTH];
    logic [11:0]           pc_d      [DEPTH];
    logic [IDX_W-1:0]      head_q, head_d;
    logic [IDX_W-1:0]      tail_q, tail_d;
    logic [IDX_W:0]        count_q, count_d;

    logic [IDX_W-1:0]      lane_idx [RETIRE_WIDTH];
    logic [RETIRE_WIDTH-1:0] ret_act;
    logic [NRET_W-1:0]     nret;
    logic                  prefix_ok;
    logic                  alloc_fire;

    assign alloc_ready = (count_q != (IDX_W+1)'(DEPTH));
    assign alloc_idx   = tail_q;
    assign count       = count_q;
    assign alloc_fire  = alloc_valid & alloc_ready;

    // Retirement: lane k is active only while every entry from head to
    // head+k is valid and done, so retirement is a contiguous in-order prefix.
    // A flush suppresses all lanes in its cycle.
    always_comb begin
        prefix_ok = ~flush;
        nret      = '0;
        ret_act   = '0;
        ret_valid = '0;
        free_push = '0;
        ret_rd    = '0;
        ret_prd   = '0;
        ret_pc    = '0;
        free_reg  = '0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            lane_idx[k] = head_q + IDX_W'(k);
            prefix_ok   = prefix_ok & valid_q[lane_idx[k]] & done_q[lane_idx[k]];
            ret_act[k]  = prefix_ok;
            if (prefix_ok) begin
                nret = nret + NRET_W'(1);
                ret_rd[k*AREG_WIDTH +: AREG_WIDTH]   = rd_q[lane_idx[k]];
                ret_prd[k*PREG_WIDTH +: PREG_WIDTH]  = prd_q[lane_idx[k]];
                ret_pc[k*12 +: 12]                   = pc_q[lane_idx[k]];
                free_reg[k*PREG_WIDTH +: PREG_WIDTH] = old_prd_q[lane_idx[k]];
                free_push[k]                         = reg_wr_q[lane_idx[k]];
            end
        end
        ret_valid = ret_act;
    end

    // Next state. Order matters: completion first, then retirement clears
    // (a late completion on a retiring entry must not resurrect it), then the
    // new allocation at tail. Tail never equals a retiring entry because an
    // allocation cannot fire while the buffer is full.
    always_comb begin
        valid_d  = valid_q;
        done_d   = done_q;
        reg_wr_d = reg_wr_q;
        for (int i = 0; i < DEPTH; i++) begin
            rd_d[i]      = rd_q[i];
            prd_d[i]     = prd_q[i];
            old_prd_d[i] = old_prd_q[i];
            pc_d[i]      = pc_q[i];
        end
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Completions to entries that are not live are ignored.
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (cmpl_valid[p] && valid_q[cmpl_idx[p*IDX_W +: IDX_W]]) begin
                    done_d[cmpl_idx[p*IDX_W +: IDX_W]] = 1'b1;
                end
            end
            for (int k = 0; k < RETIRE_WIDTH; k++) begin
                if (ret_act[k]) begin
                    valid_d[lane_idx[k]] = 1'b0;
                    done_d[lane_idx[k]]  = 1'b0;
                end
            end
            if (alloc_fire) begin
                valid_d[tail_q]   = 1'b1;
                done_d[tail_q]    = 1'b0;
                reg_wr_d[tail_q]  = alloc_reg_wr;
                rd_d[tail_q]      = alloc_rd;
                prd_d[tail_q]     = alloc_prd;
                old_prd_d[tail_q] = alloc_old_prd;
                pc_d[tail_q]      = alloc_pc;
                tail_d            = tail_q + IDX_W'(1);
            end
            head_d  = head_q + IDX_W'(nret);
            count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(nret);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            done_q   <= '0;
            reg_wr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]      <= '0;
                prd_q[i]     <= '0;
                old_prd_q[i] <= '0;
                pc_q[i]      <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q  <= valid_d;
            done_q   <= done_d;
            reg_wr_q <= reg_wr_d;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]      <= rd_d[i];
                prd_q[i]     <= prd_d[i];
                old_prd_q[i] <= old_prd_d[i];
                pc_q[i]      <= pc_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_rob.sv
module tb_rob;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic        alloc_reg_wr;
    logic [4:0]  alloc_rd;
    logic [5:0]  alloc_prd;
    logic [5:0]  alloc_old_prd;
    logic [11:0] alloc_pc;
    logic [5:0]  alloc_idx;
    logic [2:0]  cmpl_valid;
    logic [17:0] cmpl_idx;
    logic [1:0]  ret_valid;
    logic [9:0]  ret_rd;
    logic [11:0] ret_prd;
    logic [23:0] ret_pc;
    logic [1:0]  free_push;
    logic [11:0] free_reg;
    logic [6:0]  count;

    int checks = 0;
    int errors = 0;

    rob dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_reg_wr(alloc_reg_wr), .alloc_rd(alloc_rd), .alloc_prd(alloc_prd),
        .alloc_old_prd(alloc_old_prd), .alloc_pc(alloc_pc), .alloc_idx(alloc_idx),
        .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
        .ret_valid(ret_valid), .ret_rd(ret_rd), .ret_prd(ret_prd), .ret_pc(ret_pc),
        .free_push(free_push), .free_reg(free_reg), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_alloc(input logic wr, input logic [4:0] rd, input logic [5:0] prd,
                             input logic [5:0] old, input logic [11:0] pc);
        alloc_valid   = 1'b1;
        alloc_reg_wr  = wr;
        alloc_rd      = rd;
        alloc_prd     = prd;
        alloc_old_prd = old;
        alloc_pc      = pc;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_reg_wr = 1'b0;
        alloc_rd = '0; alloc_prd = '0; alloc_old_prd = '0; alloc_pc = '0;
        cmpl_valid = '0; cmpl_idx = '0;
        #12 rst = 1'b0;

        // Reset values
        chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("rst_alloc_idx", 32'(alloc_idx), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ret_valid", 32'(ret_valid), 32'd0);
        chk("rst_free_push", 32'(free_push), 32'd0);
        chk("rst_ret_prd", 32'(ret_prd), 32'd0);

        // 1: three allocations
        set_alloc(1'b1, 5'd1, 6'd33, 6'd1, 12'h100);
        chk("t1_idx0", 32'(alloc_idx), 32'd0);
        tick();
        set_alloc(1'b1, 5'd2, 6'd34, 6'd2, 12'h104);
        chk("t1_idx1", 32'(alloc_idx), 32'd1);
        tick();
        set_alloc(1'b1, 5'd3, 6'd35, 6'd3, 12'h108);
        chk("t1_idx2", 32'(alloc_idx), 32'd2);
        tick();
        alloc_valid = 1'b0;
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_no_ret", 32'(ret_valid), 32'd0);

        // 2: out-of-order completion 2, 1, 0
        cmpl_valid = 3'b001; cmpl_idx = {6'd0, 6'd0, 6'd2};
        tick();
        chk("t2_after_c2", 32'(ret_valid), 32'd0);
        cmpl_idx = {6'd0, 6'd0, 6'd1};
        tick();
        chk("t2_after_c1", 32'(ret_valid), 32'd0);
        cmpl_idx = {6'd0, 6'd0, 6'd0};
        tick();
        cmpl_valid = '0;
        chk("t2_ret_pair", 32'(ret_valid), 32'b11);
        chk("t2_free_reg_pair", 32'(free_reg), 32'({6'd2, 6'd1}));
        chk("t2_free_push_pair", 32'(free_push), 32'b11);
        chk("t2_ret_prd_pair", 32'(ret_prd), 32'({6'd34, 6'd33}));
        chk("t2_ret_rd_pair", 32'(ret_rd), 32'({5'd2, 5'd1}));
        tick();
        chk("t2_ret_last", 32'(ret_valid), 32'b01);
        chk("t2_free_reg_last", 32'(free_reg[5:0]), 32'd3);
        chk("t2_ret_pc_last", 32'(ret_pc[11:0]), 32'h108);
        tick();
        chk("t2_count_empty", 32'(count), 32'd0);
        chk("t2_ret_idle", 32'(ret_valid), 32'd0);

        // 5: entry without a register write (idx 3)
        set_alloc(1'b0, 5'd7, 6'd40, 6'd9, 12'h10C);
        chk("t5_idx", 32'(alloc_idx), 32'd3);
        tick();
        alloc_valid = 1'b0;
        cmpl_valid = 3'b010; cmpl_idx = {6'd0, 6'd3, 6'd0};
        tick();
        cmpl_valid = '0;
        chk("t5_ret_valid", 32'(ret_valid), 32'b01);
        chk("t5_free_push", 32'(free_push), 32'b00);
        chk("t5_ret_rd", 32'(ret_rd[4:0]), 32'd7);
        chk("t5_ret_prd", 32'(ret_prd[5:0]), 32'd40);
        tick();
        chk("t5_count", 32'(count), 32'd0);

        // 3: fill all 64 entries starting at idx 4
        for (int i = 0; i < 64; i++) begin
            set_alloc(1'b1, 5'(i), 6'(i), 6'(i + 1), 12'(i));
            tick();
        end
        chk("t3_count_full", 32'(count), 32'd64);
        chk("t3_ready_low", 32'(alloc_ready), 32'd0);
        chk("t3_idx_full", 32'(alloc_idx), 32'd4);
        tick();
        chk("t3_ignored_count", 32'(count), 32'd64);
        chk("t3_ignored_idx", 32'(alloc_idx), 32'd4);
        cmpl_valid = 3'b011; cmpl_idx = {6'd0, 6'd5, 6'd4};
        tick();
        chk("t3_ret_full", 32'(ret_valid), 32'b11);
        chk("t3_ret_prd_full", 32'(ret_prd), 32'({6'd1, 6'd0}));
        chk("t3_ready_still_low", 32'(alloc_ready), 32'd0);
        chk("t3_count_before", 32'(count), 32'd64);
        alloc_valid = 1'b0; cmpl_valid = '0;
        tick();
        chk("t3_count_after", 32'(count), 32'd62);
        chk("t3_ready_high", 32'(alloc_ready), 32'd1);
        for (int i = 2; i < 64; i++) begin
            cmpl_valid = 3'b001; cmpl_idx = {12'd0, 6'((4 + i) % 64)};
            tick();
        end
        cmpl_valid = '0;
        tick();
        tick();
        chk("t3_drained", 32'(count), 32'd0);

        // 4: wrap through the DEPTH boundary (head/tail move 4 -> 63)
        for (int i = 0; i < 59; i++) begin
            set_alloc(1'b1, 5'd0, 6'(i), 6'd0, 12'd0);
            tick();
        end
        alloc_valid = 1'b0;
        for (int i = 0; i < 59; i++) begin
            cmpl_valid = 3'b001; cmpl_idx = {12'd0, 6'(4 + i)};
            tick();
        end
        cmpl_valid = '0;
        tick();
        tick();
        chk("t4_pre_count", 32'(count), 32'd0);
        set_alloc(1'b1, 5'd10, 6'd50, 6'd20, 12'h3F0);
        chk("t4_idx63", 32'(alloc_idx), 32'd63);
        tick();
        set_alloc(1'b1, 5'd11, 6'd51, 6'd21, 12'h400);
        chk("t4_idx0", 32'(alloc_idx), 32'd0);
        tick();
        alloc_valid = 1'b0;
        cmpl_valid = 3'b101; cmpl_idx = {6'd0, 6'd0, 6'd63};
        tick();
        cmpl_valid = '0;
        chk("t4_ret_valid", 32'(ret_valid), 32'b11);
        chk("t4_ret_prd", 32'(ret_prd), 32'({6'd51, 6'd50}));
        chk("t4_ret_pc", 32'(ret_pc), 32'({12'h400, 12'h3F0}));
        chk("t4_free_reg", 32'(free_reg), 32'({6'd21, 6'd20}));
        tick();
        chk("t4_count", 32'(count), 32'd0);

        // 6: flush with 5 entries (idx 1..5), two retire-ready
        for (int i = 0; i < 5; i++) begin
            set_alloc(1'b1, 5'd0, 6'(i), 6'(i), 12'd0);
            tick();
        end
        alloc_valid = 1'b0;
        cmpl_valid = 3'b011; cmpl_idx = {6'd0, 6'd2, 6'd1};
        tick();
        chk("t6_ret_ready", 32'(ret_valid), 32'b11);
        chk("t6_count5", 32'(count), 32'd5);
        flush = 1'b1; alloc_valid = 1'b1;
        cmpl_valid = 3'b001; cmpl_idx = {12'd0, 6'd3};
        #1;
        chk("t6_flush_ret", 32'(ret_valid), 32'b00);
        chk("t6_flush_push", 32'(free_push), 32'b00);
        tick();
        flush = 1'b0; alloc_valid = 1'b0; cmpl_valid = '0;
        chk("t6_count0", 32'(count), 32'd0);
        chk("t6_idx0", 32'(alloc_idx), 32'd0);
        chk("t6_ret_idle", 32'(ret_valid), 32'd0);
        // stale completion to an empty slot must not mark it done
        cmpl_valid = 3'b001; cmpl_idx = {12'd0, 6'd3};
        tick();
        cmpl_valid = '0;
        for (int i = 0; i < 4; i++) begin
            set_alloc(1'b1, 5'd0, 6'(i), 6'(i), 12'd0);
            tick();
        end
        alloc_valid = 1'b0;
        cmpl_valid = 3'b111; cmpl_idx = {6'd2, 6'd1, 6'd0};
        tick();
        cmpl_valid = '0;
        chk("t6_post_ret01", 32'(ret_valid), 32'b11);
        tick();
        chk("t6_post_ret2", 32'(ret_valid), 32'b01);
        tick();
        chk("t6_stale_ignored", 32'(ret_valid), 32'b00);
        chk("t6_count1", 32'(count), 32'd1);

        // asynchronous reset mid-operation, away from any clock edge
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_idx", 32'(alloc_idx), 32'd0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
